// File: rtl/bus_router_pkg.sv
// Shared response codes, channel FSM states and the linear address decoder.
package bus_router_pkg;

  localparam logic [1:0] RESP_OK     = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] sel;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] addr,
                                  input int unsigned region_size,
                                  input int unsigned num_slaves);
    dec_t        d;
    int unsigned idx;
    idx   = addr / region_size;
    d.hit = (idx < num_slaves);
    d.sel = idx[2:0];
    return d;
  endfunction

endpackage

// File: rtl/bus_router_chan.sv
// One request channel: accept, route to a slave or flag DECERR, wait with timeout, answer.
// Latency: slave answering k cycles after s_valid gives m_ready k+2 cycles after accept; one outstanding request.
module bus_router_chan
  import bus_router_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int PAY_W       = 12,
  parameter int RDATA_W     = 8,
  parameter int NUM_SLAVES  = 3,
  parameter int REGION_SIZE = 'h40,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          m_valid,
  input  logic [ADDR_W-1:0]             m_addr,
  input  logic [PAY_W-1:0]              m_pay,
  output logic                          m_ready,
  output logic [1:0]                    m_resp,
  output logic [RDATA_W-1:0]            m_data,
  output logic [NUM_SLAVES-1:0]         s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [PAY_W-1:0]              s_pay,
  input  logic [NUM_SLAVES-1:0]         s_ready,
  input  logic [2*NUM_SLAVES-1:0]       s_resp,
  input  logic [RDATA_W*NUM_SLAVES-1:0] s_data,
  output logic                          err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  state_t           state;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;

  always_comb dec = decode(32'(m_addr), REGION_SIZE, NUM_SLAVES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sel     <= '0;
      cnt     <= '0;
      m_ready <= 1'b0;
      m_resp  <= RESP_OK;
      m_data  <= '0;
      s_valid <= '0;
      s_addr  <= '0;
      s_pay   <= '0;
      err     <= 1'b0;
    end else begin
      m_ready <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_addr <= m_addr;
            s_pay  <= m_pay;
            sel    <= SEL_W'(dec.sel);
            cnt    <= '0;
            if (dec.hit) begin
              s_valid <= NUM_SLAVES'(1) << dec.sel;
              state   <= FWD;
            end else begin
              state <= ERR;
            end
          end
        end
        FWD: begin
          // A real answer on the final timeout cycle still wins over the timeout.
          if (s_ready[sel]) begin
            m_resp  <= s_resp[sel*2 +: 2];
            m_data  <= s_data[sel*RDATA_W +: RDATA_W];
            m_ready <= 1'b1;
            s_valid <= '0;
            state   <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC-1)) begin
            m_resp  <= RESP_SLVERR;
            m_data  <= '0;
            m_ready <= 1'b1;
            err     <= 1'b1;
            s_valid <= '0;
            state   <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ERR: begin
          m_resp  <= RESP_DECERR;
          m_data  <= '0;
          m_ready <= 1'b1;
          err     <= 1'b1;
          state   <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/bus_router_n.sv
// Registered master-to-N-slave router: independent write and read channels plus a saturating error counter.
// Latency k+2 cycles for a slave answering in k, 2 cycles for DECERR; one outstanding request per channel.
module bus_router_n
  import bus_router_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int ID_W        = 4,
  parameter int NUM_SLAVES  = 3,
  parameter int REGION_SIZE = 'h40,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_w_valid,
  input  logic [ADDR_W-1:0]            m_w_addr,
  input  logic [DATA_W-1:0]            m_w_data,
  input  logic [ID_W-1:0]              m_w_id,
  output logic                         m_w_ready,
  output logic [1:0]                   m_w_resp,
  input  logic                         m_r_valid,
  input  logic [ADDR_W-1:0]            m_r_addr,
  input  logic [ID_W-1:0]              m_r_id,
  output logic                         m_r_ready,
  output logic [DATA_W-1:0]            m_r_data,
  output logic [1:0]                   m_r_resp,
  output logic [NUM_SLAVES-1:0]        s_w_valid,
  output logic [ADDR_W-1:0]            s_w_addr,
  output logic [DATA_W-1:0]            s_w_data,
  output logic [ID_W-1:0]              s_w_id,
  input  logic [NUM_SLAVES-1:0]        s_w_ready,
  input  logic [2*NUM_SLAVES-1:0]      s_w_resp,
  output logic [NUM_SLAVES-1:0]        s_r_valid,
  output logic [ADDR_W-1:0]            s_r_addr,
  output logic [ID_W-1:0]              s_r_id,
  input  logic [NUM_SLAVES-1:0]        s_r_ready,
  input  logic [DATA_W*NUM_SLAVES-1:0] s_r_data,
  input  logic [2*NUM_SLAVES-1:0]      s_r_resp,
  output logic [7:0]                   err_count
);

  logic              w_err;
  logic              r_err;
  logic [DATA_W-1:0] w_rdata_unused;
  logic [8:0]        err_sum;

  bus_router_chan #(
    .ADDR_W(ADDR_W), .PAY_W(DATA_W+ID_W), .RDATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
    .REGION_SIZE(REGION_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wr (
    .clk(clk), .rst(rst),
    .m_valid(m_w_valid), .m_addr(m_w_addr), .m_pay({m_w_data, m_w_id}),
    .m_ready(m_w_ready), .m_resp(m_w_resp), .m_data(w_rdata_unused),
    .s_valid(s_w_valid), .s_addr(s_w_addr), .s_pay({s_w_data, s_w_id}),
    .s_ready(s_w_ready), .s_resp(s_w_resp), .s_data('0),
    .err(w_err)
  );

  bus_router_chan #(
    .ADDR_W(ADDR_W), .PAY_W(ID_W), .RDATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
    .REGION_SIZE(REGION_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rd (
    .clk(clk), .rst(rst),
    .m_valid(m_r_valid), .m_addr(m_r_addr), .m_pay(m_r_id),
    .m_ready(m_r_ready), .m_resp(m_r_resp), .m_data(m_r_data),
    .s_valid(s_r_valid), .s_addr(s_r_addr), .s_pay(s_r_id),
    .s_ready(s_r_ready), .s_resp(s_r_resp), .s_data(s_r_data),
    .err(r_err)
  );

  // Only router-generated errors (DECERR, timeout) count; slave SLVERR passes through uncounted.
  always_comb err_sum = {1'b0, err_count} + 9'(w_err) + 9'(r_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
  end

endmodule

// File: tb/tb_bus_router_n.sv
module tb_bus_router_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_w_valid = 1'b0;
  logic [7:0]  m_w_addr = '0, m_w_data = '0;
  logic [3:0]  m_w_id = '0;
  logic        m_w_ready;
  logic [1:0]  m_w_resp;
  logic        m_r_valid = 1'b0;
  logic [7:0]  m_r_addr = '0;
  logic [3:0]  m_r_id = '0;
  logic        m_r_ready;
  logic [7:0]  m_r_data;
  logic [1:0]  m_r_resp;
  logic [2:0]  s_w_valid;
  logic [7:0]  s_w_addr, s_w_data;
  logic [3:0]  s_w_id;
  logic [2:0]  s_w_ready = '0;
  logic [5:0]  s_w_resp = '0;
  logic [2:0]  s_r_valid;
  logic [7:0]  s_r_addr;
  logic [3:0]  s_r_id;
  logic [2:0]  s_r_ready = '0;
  logic [23:0] s_r_data = '0;
  logic [5:0]  s_r_resp = '0;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  bus_router_n dut (
    .clk(clk), .rst(rst),
    .m_w_valid(m_w_valid), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_id(m_w_id),
    .m_w_ready(m_w_ready), .m_w_resp(m_w_resp),
    .m_r_valid(m_r_valid), .m_r_addr(m_r_addr), .m_r_id(m_r_id),
    .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .s_w_valid(s_w_valid), .s_w_addr(s_w_addr), .s_w_data(s_w_data), .s_w_id(s_w_id),
    .s_w_ready(s_w_ready), .s_w_resp(s_w_resp),
    .s_r_valid(s_r_valid), .s_r_addr(s_r_addr), .s_r_id(s_r_id),
    .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // slave = -1 means no slave owns the address; k = -1 means the slave never answers.
  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] id;
    int         slave;
    int         k;
    logic [1:0] sresp;
    logic [7:0] sdata;
    bit         noise;
    int         exp_lat;
    int         exp_cnt;
    logic [1:0] exp_resp;
    logic [7:0] exp_data;
    int         exp_err;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [7:0] addr, logic [7:0] data, logic [3:0] id,
                              int slave, int k, logic [1:0] sresp, logic [7:0] sdata, bit noise,
                              int lat, int cnt, logic [1:0] eresp, logic [7:0] edata, int eerr);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.id = id; v.slave = slave; v.k = k;
    v.sresp = sresp; v.sdata = sdata; v.noise = noise; v.exp_lat = lat; v.exp_cnt = cnt;
    v.exp_resp = eresp; v.exp_data = edata; v.exp_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Slot 0 drives the write channel, slot 1 the read channel; both may run together.
  task automatic run(input string tag, input vec_t wv, input bit wen, input vec_t rv, input bit ren);
    vec_t       v[2];
    bit         en[2];
    int         lat[2], pulses[2], vcnt[2], stray[2], payerr[2];
    logic [1:0] gresp[2];
    logic [7:0] gdata[2];
    logic [2:0] oh[2];
    logic [2:0] sv, rdy;
    logic [5:0] rsp;
    logic [23:0] dat;
    logic       mr;
    logic [7:0] e0;
    int         edel;
    v[0] = wv; v[1] = rv; en[0] = wen; en[1] = ren;
    edel = 0;
    for (int c = 0; c < 2; c++) begin
      lat[c] = 0; pulses[c] = 0; vcnt[c] = 0; stray[c] = 0; payerr[c] = 0;
      gresp[c] = 'x; gdata[c] = 'x;
      oh[c] = (en[c] && v[c].slave >= 0) ? 3'(1 << v[c].slave) : 3'b000;
      if (en[c]) edel += v[c].exp_err;
    end
    e0 = err_count;
    @(negedge clk);
    if (wen) begin m_w_valid = 1'b1; m_w_addr = wv.addr; m_w_data = wv.data; m_w_id = wv.id; end
    if (ren) begin m_r_valid = 1'b1; m_r_addr = rv.addr; m_r_id = rv.id; end
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 1) begin
        m_w_valid = 1'b0; m_r_valid = 1'b0;
        m_w_addr = ~m_w_addr; m_w_data = ~m_w_data; m_w_id = ~m_w_id;
        m_r_addr = ~m_r_addr; m_r_id = ~m_r_id;
      end
      for (int c = 0; c < 2; c++) begin
        if (!en[c]) continue;
        sv = (c == 0) ? s_w_valid : s_r_valid;
        mr = (c == 0) ? m_w_ready : m_r_ready;
        if (sv != 3'b000) begin
          vcnt[c]++;
          if (sv !== oh[c]) stray[c]++;
          if (c == 0) begin
            if (s_w_addr !== v[0].addr || s_w_data !== v[0].data || s_w_id !== v[0].id) payerr[c]++;
          end else begin
            if (s_r_addr !== v[1].addr || s_r_id !== v[1].id) payerr[c]++;
          end
        end
        if (mr === 1'b1) begin
          pulses[c]++;
          if (lat[c] == 0) begin
            lat[c] = n;
            gresp[c] = (c == 0) ? m_w_resp : m_r_resp;
            gdata[c] = (c == 0) ? 8'h00 : m_r_data;
          end
        end
        rdy = v[c].noise ? ~oh[c] : 3'b000;
        rsp = 6'h3F;
        dat = 24'hFFFFFF;
        if (v[c].slave >= 0 && v[c].k >= 0 && n == v[c].k + 1) begin
          rdy = rdy | oh[c];
          rsp[2*v[c].slave +: 2] = v[c].sresp;
          dat[8*v[c].slave +: 8] = v[c].sdata;
        end
        if (c == 0) begin s_w_ready = rdy; s_w_resp = rsp; end
        else begin s_r_ready = rdy; s_r_resp = rsp; s_r_data = dat; end
      end
    end
    s_w_ready = '0; s_r_ready = '0;
    for (int c = 0; c < 2; c++) begin
      if (!en[c]) continue;
      chk($sformatf("%s_%s_latency", tag, c ? "r" : "w"), lat[c], v[c].exp_lat);
      chk($sformatf("%s_%s_pulses", tag, c ? "r" : "w"), pulses[c], 1);
      chk($sformatf("%s_%s_resp", tag, c ? "r" : "w"), gresp[c], v[c].exp_resp);
      if (c == 1) chk($sformatf("%s_r_data", tag), gdata[c], v[c].exp_data);
      chk($sformatf("%s_%s_svalid_cycles", tag, c ? "r" : "w"), vcnt[c], v[c].exp_cnt);
      chk($sformatf("%s_%s_svalid_stray", tag, c ? "r" : "w"), stray[c], 0);
      chk($sformatf("%s_%s_payload", tag, c ? "r" : "w"), payerr[c], 0);
    end
    chk($sformatf("%s_err_count", tag), err_count, 32'(e0) + 32'(edel));
  endtask

  vec_t vt[11];
  vec_t nil;

  initial begin
    int pulses;
    nil = mk(0, 8'h00, 8'h00, 4'h0, -1, -1, 2'b00, 8'h00, 0, 0, 0, 2'b00, 8'h00, 0);
    //            wr addr   data   id    sl  k   sresp  sdata  nz lat cnt eresp  edata  err
    vt[0]  = mk(1, 8'h10, 8'hA5, 4'h3,  0,  2, 2'b00, 8'h00, 0,  4,  3, 2'b00, 8'h00, 0);
    vt[1]  = mk(0, 8'h85, 8'h00, 4'h5,  2,  1, 2'b00, 8'h3C, 0,  3,  2, 2'b00, 8'h3C, 0);
    vt[2]  = mk(1, 8'hC0, 8'h11, 4'h1, -1, -1, 2'b00, 8'h00, 0,  2,  0, 2'b11, 8'h00, 1);
    vt[3]  = mk(0, 8'h7F, 8'h00, 4'h7,  1, -1, 2'b00, 8'h00, 0, 17, 16, 2'b10, 8'h00, 1);
    vt[4]  = mk(0, 8'hBF, 8'h00, 4'h2,  2,  0, 2'b10, 8'h77, 1,  2,  1, 2'b10, 8'h77, 0);
    vt[5]  = mk(1, 8'hBF, 8'h5C, 4'h9,  2,  3, 2'b10, 8'h00, 1,  5,  4, 2'b10, 8'h00, 0);
    vt[6]  = mk(0, 8'hC0, 8'h00, 4'h4, -1, -1, 2'b00, 8'h00, 0,  2,  0, 2'b11, 8'h00, 1);
    vt[7]  = mk(1, 8'h40, 8'h33, 4'hA,  1,  0, 2'b00, 8'h00, 0,  2,  1, 2'b00, 8'h00, 0);
    vt[8]  = mk(0, 8'hFF, 8'h00, 4'hF, -1, -1, 2'b00, 8'h00, 0,  2,  0, 2'b11, 8'h00, 1);
    vt[9]  = mk(1, 8'h3F, 8'hC3, 4'h6,  0,  1, 2'b00, 8'h00, 0,  3,  2, 2'b00, 8'h00, 0);
    vt[10] = mk(1, 8'h80, 8'hE1, 4'h2,  2, -1, 2'b00, 8'h00, 1, 17, 16, 2'b10, 8'h00, 1);

    #12;
    chk("reset_outputs", {m_w_ready, m_r_ready, s_w_valid, s_r_valid, err_count, m_w_resp, m_r_resp, m_r_data},
        32'h0);
    chk("reset_payload", {s_w_addr, s_w_data, s_r_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) run($sformatf("vec%0d", i), vt[i], 1'b1, nil, 1'b0);
      else          run($sformatf("vec%0d", i), nil, 1'b0, vt[i], 1'b1);
    end

    run("par_diff", mk(1, 8'h00, 8'h96, 4'h1, 0, 1, 2'b00, 8'h00, 0, 3, 2, 2'b00, 8'h00, 0), 1'b1,
                    mk(0, 8'h40, 8'h00, 4'h2, 1, 2, 2'b00, 8'h5A, 0, 4, 3, 2'b00, 8'h5A, 0), 1'b1);
    run("par_same", mk(1, 8'h88, 8'h44, 4'h3, 2, 0, 2'b00, 8'h00, 0, 2, 1, 2'b00, 8'h00, 0), 1'b1,
                    mk(0, 8'h90, 8'h00, 4'h4, 2, 3, 2'b00, 8'hE7, 0, 5, 4, 2'b00, 8'hE7, 0), 1'b1);
    run("par_decerr", mk(1, 8'hC8, 8'h00, 4'h5, -1, -1, 2'b00, 8'h00, 0, 2, 0, 2'b11, 8'h00, 1), 1'b1,
                      mk(0, 8'hD0, 8'h00, 4'h6, -1, -1, 2'b00, 8'h00, 0, 2, 0, 2'b11, 8'h00, 1), 1'b1);

    // Abort a write stuck in FWD with an asynchronous reset between clock edges.
    @(negedge clk);
    m_w_valid = 1'b1; m_w_addr = 8'h50; m_w_data = 8'h12; m_w_id = 4'h8;
    @(negedge clk);
    m_w_valid = 1'b0;
    chk("rst_pre_svalid", s_w_valid, 3'b010);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rst_async_svalid", s_w_valid, 3'b000);
    chk("rst_async_err_count", err_count, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (m_w_ready === 1'b1) pulses++;
    end
    chk("rst_no_response", pulses, 0);
    run("post_rst", vt[0], 1'b1, nil, 1'b0);

    // Drive dual DECERRs until the counter must have saturated.
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      m_w_valid = 1'b1; m_w_addr = 8'hC0;
      m_r_valid = 1'b1; m_r_addr = 8'hF4;
      @(negedge clk);
      m_w_valid = 1'b0; m_r_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    chk("err_count_saturate", err_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
